// File: rtl/clause_evaluator.sv
// ============================================================================
// Module      : clause_evaluator
// Description : BCP scan engine. Walks clauses 0..num_clauses-1 from the clause
//               database, classifies each one against the current assignment
//               as SAT / UNIT / CONFLICT / UNRESOLVED, emits implied literals
//               over a valid/ready handshake and reports the first conflict.
//               Optional per-class statistics counters are enabled by defining
//               CLAUSE_EVAL_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module clause_evaluator #(
    parameter int VAR_PER_CLAUSE   = 5,
    parameter int MAX_VARS         = 32,
    parameter int MAX_VARS_BITS    = 5,
    parameter int MAX_CLAUSES_BITS = 8
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    start,
    input  logic [MAX_CLAUSES_BITS:0]               num_clauses,
    input  logic [MAX_VARS-1:0]                     assign_valid,
    input  logic [MAX_VARS-1:0]                     assign_val,
    output logic                                    db_read,
    output logic [MAX_CLAUSES_BITS-1:0]             db_index,
    input  logic [VAR_PER_CLAUSE-1:0]               db_mask,
    input  logic [VAR_PER_CLAUSE-1:0]               db_pole,
    input  logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] db_var,
    input  logic                                    db_error,
    output logic                                    busy,
    output logic                                    done,
    output logic                                    conflict,
    output logic [MAX_CLAUSES_BITS-1:0]             conflict_idx,
    output logic                                    error,
    output logic                                    unit_valid,
    output logic [MAX_VARS_BITS-1:0]                unit_var,
    output logic                                    unit_val,
    input  logic                                    unit_ready
`ifdef CLAUSE_EVAL_STATS_EN
    ,
    output logic [MAX_CLAUSES_BITS:0]               stat_sat,
    output logic [MAX_CLAUSES_BITS:0]               stat_unit,
    output logic [MAX_CLAUSES_BITS:0]               stat_unres
`endif
);

    // Clause count width (one bit wider than an index so a full table fits).
    localparam int c_cnt_w  = MAX_CLAUSES_BITS + 1;
    // Width needed to count unassigned lanes 0..VAR_PER_CLAUSE.
    localparam int c_lane_w = $clog2(VAR_PER_CLAUSE + 1);

    localparam logic [c_lane_w-1:0] c_lane_zero = '0;
    localparam logic [c_lane_w-1:0] c_lane_one  = {{(c_lane_w-1){1'b0}}, 1'b1};
    localparam logic [c_cnt_w-1:0]  c_cnt_one   = {{(c_cnt_w-1){1'b0}}, 1'b1};
    localparam logic [MAX_CLAUSES_BITS-1:0] c_idx_one = {{(MAX_CLAUSES_BITS-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_READ     = 3'd1,
        S_EVAL     = 3'd2,
        S_UNIT_OUT = 3'd3,
        S_NEXT     = 3'd4,
        S_FIN      = 3'd5
    } state_t;

    state_t                              r_state;
    state_t                              w_state_next;

    logic [MAX_CLAUSES_BITS-1:0]         r_idx;
    logic [c_cnt_w-1:0]                  r_num_clauses;
    logic [VAR_PER_CLAUSE-1:0]           r_mask;
    logic [VAR_PER_CLAUSE-1:0]           r_pole;
    logic [VAR_PER_CLAUSE*MAX_VARS_BITS-1:0] r_var;
    logic                                r_db_err;
    logic                                r_conflict;
    logic [MAX_CLAUSES_BITS-1:0]         r_conflict_idx;
    logic                                r_error;
    logic [MAX_VARS_BITS-1:0]            r_unit_var;
    logic                                r_unit_val;

    logic [VAR_PER_CLAUSE-1:0]           w_lane_true;
    logic [VAR_PER_CLAUSE-1:0]           w_lane_unasgn;
    logic [c_lane_w-1:0]                 w_unasgn_cnt;
    logic [MAX_VARS_BITS-1:0]            w_unit_var;
    logic                                w_unit_val;
    logic                                w_is_sat;
    logic                                w_is_conflict;
    logic                                w_is_unit;
    logic                                w_is_unres;
    logic [c_cnt_w-1:0]                  w_last_idx;
    logic                                w_is_last;
    logic                                w_start_ok;

    // ------------------------------------------------------------------
    // Per-lane literal status against the live assignment vectors
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < VAR_PER_CLAUSE; g++) begin : g_lane
            logic [MAX_VARS_BITS-1:0] w_var;
            assign w_var            = r_var[g*MAX_VARS_BITS +: MAX_VARS_BITS];
            assign w_lane_true[g]   = r_mask[g] && assign_valid[w_var]
                                      && (assign_val[w_var] == r_pole[g]);
            assign w_lane_unasgn[g] = r_mask[g] && !assign_valid[w_var];
        end
    endgenerate

    // Count unassigned lanes and pick the literal of the (single) unassigned one
    always_comb begin
        w_unasgn_cnt = c_lane_zero;
        w_unit_var   = '0;
        w_unit_val   = 1'b0;
        for (int i = 0; i < VAR_PER_CLAUSE; i++) begin
            if (w_lane_unasgn[i]) begin
                w_unasgn_cnt = w_unasgn_cnt + c_lane_one;
                w_unit_var   = r_var[i*MAX_VARS_BITS +: MAX_VARS_BITS];
                w_unit_val   = r_pole[i];
            end
        end
    end

    // Classification: SAT dominates, then CONFLICT (nothing left open),
    // then UNIT (exactly one open lane), otherwise UNRESOLVED.
    assign w_is_sat      = |w_lane_true;
    assign w_is_conflict = !w_is_sat && (w_unasgn_cnt == c_lane_zero);
    assign w_is_unit     = !w_is_sat && (w_unasgn_cnt == c_lane_one);
    assign w_is_unres    = !w_is_sat && !w_is_conflict && !w_is_unit;

    // Full-width compare so counts above the index range never match early.
    assign w_last_idx = r_num_clauses - c_cnt_one;
    assign w_is_last  = ({1'b0, r_idx} == w_last_idx);

    assign w_start_ok = (r_state == S_IDLE) && start;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b1;
        done         = 1'b0;
        db_read      = 1'b0;
        db_index     = '0;
        unit_valid   = 1'b0;
        case (r_state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) begin
                    w_state_next = (num_clauses == '0) ? S_FIN : S_READ;
                end
            end
            S_READ: begin
                db_read      = 1'b1;
                db_index     = r_idx;
                w_state_next = S_EVAL;
            end
            S_EVAL: begin
                if (r_db_err || w_is_conflict) begin
                    w_state_next = S_FIN;
                end else if (w_is_unit) begin
                    w_state_next = S_UNIT_OUT;
                end else begin
                    w_state_next = S_NEXT;
                end
            end
            S_UNIT_OUT: begin
                unit_valid = 1'b1;
                if (unit_ready) begin
                    w_state_next = S_NEXT;
                end
            end
            S_NEXT: begin
                w_state_next = w_is_last ? S_FIN : S_READ;
            end
            S_FIN: begin
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Scan datapath: clause latch, index walk, result and implied-literal registers
    always_ff @(posedge clock) begin
        if (reset) begin
            r_idx          <= '0;
            r_num_clauses  <= '0;
            r_mask         <= '0;
            r_pole         <= '0;
            r_var          <= '0;
            r_db_err       <= 1'b0;
            r_conflict     <= 1'b0;
            r_conflict_idx <= '0;
            r_error        <= 1'b0;
            r_unit_var     <= '0;
            r_unit_val     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_num_clauses  <= num_clauses;
                        r_idx          <= '0;
                        r_conflict     <= 1'b0;
                        r_conflict_idx <= '0;
                        r_error        <= 1'b0;
                    end
                end
                S_READ: begin
                    r_mask   <= db_mask;
                    r_pole   <= db_pole;
                    r_var    <= db_var;
                    r_db_err <= db_error;
                end
                S_EVAL: begin
                    if (r_db_err) begin
                        r_error <= 1'b1;
                    end else if (w_is_conflict) begin
                        r_conflict     <= 1'b1;
                        r_conflict_idx <= r_idx;
                    end else if (w_is_unit) begin
                        r_unit_var <= w_unit_var;
                        r_unit_val <= w_unit_val;
                    end
                end
                S_NEXT: begin
                    if (!w_is_last) begin
                        r_idx <= r_idx + c_idx_one;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign conflict     = r_conflict;
    assign conflict_idx = r_conflict_idx;
    assign error        = r_error;
    assign unit_var     = r_unit_var;
    assign unit_val     = r_unit_val;

`ifdef CLAUSE_EVAL_STATS_EN
    logic [c_cnt_w-1:0] r_stat_sat;
    logic [c_cnt_w-1:0] r_stat_unit;
    logic [c_cnt_w-1:0] r_stat_unres;
    logic               w_classify;

    // A clause is classified only when its read did not report an error.
    assign w_classify = (r_state == S_EVAL) && !r_db_err;

    // Saturating per-class counters, cleared on reset and on an accepted start
    always_ff @(posedge clock) begin
        if (reset || w_start_ok) begin
            r_stat_sat   <= '0;
            r_stat_unit  <= '0;
            r_stat_unres <= '0;
        end else if (w_classify) begin
            if (w_is_sat && (r_stat_sat != '1)) begin
                r_stat_sat <= r_stat_sat + c_cnt_one;
            end
            if (w_is_unit && (r_stat_unit != '1)) begin
                r_stat_unit <= r_stat_unit + c_cnt_one;
            end
            if (w_is_unres && (r_stat_unres != '1)) begin
                r_stat_unres <= r_stat_unres + c_cnt_one;
            end
        end
    end

    assign stat_sat   = r_stat_sat;
    assign stat_unit  = r_stat_unit;
    assign stat_unres = r_stat_unres;
`else
    // Without statistics, these decodes have no consumer.
    logic w_unused;
    assign w_unused = w_start_ok ^ w_is_unres;
`endif

endmodule

`default_nettype wire

// File: tb/tb_clause_evaluator.sv
// ============================================================================
// Module      : tb_clause_evaluator
// Description : Directed, table-driven bench for clause_evaluator. A small
//               array model of the clause database answers db_index reads.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_clause_evaluator;

    logic        clock;
    logic        reset;
    logic        start;
    logic [8:0]  num_clauses;
    logic [31:0] assign_valid;
    logic [31:0] assign_val;
    logic        db_read;
    logic [7:0]  db_index;
    logic [4:0]  db_mask;
    logic [4:0]  db_pole;
    logic [24:0] db_var;
    logic        db_error;
    logic        busy;
    logic        done;
    logic        conflict;
    logic [7:0]  conflict_idx;
    logic        error;
    logic        unit_valid;
    logic [4:0]  unit_var;
    logic        unit_val;
    logic        unit_ready;
`ifdef CLAUSE_EVAL_STATS_EN
    logic [8:0]  stat_sat;
    logic [8:0]  stat_unit;
    logic [8:0]  stat_unres;
`endif

    clause_evaluator dut (
        .clock        (clock),
        .reset        (reset),
        .start        (start),
        .num_clauses  (num_clauses),
        .assign_valid (assign_valid),
        .assign_val   (assign_val),
        .db_read      (db_read),
        .db_index     (db_index),
        .db_mask      (db_mask),
        .db_pole      (db_pole),
        .db_var       (db_var),
        .db_error     (db_error),
        .busy         (busy),
        .done         (done),
        .conflict     (conflict),
        .conflict_idx (conflict_idx),
        .error        (error),
        .unit_valid   (unit_valid),
        .unit_var     (unit_var),
        .unit_val     (unit_val),
        .unit_ready   (unit_ready)
`ifdef CLAUSE_EVAL_STATS_EN
        ,
        .stat_sat     (stat_sat),
        .stat_unit    (stat_unit),
        .stat_unres   (stat_unres)
`endif
    );

    // Clause database model: combinational lookup on db_index.
    logic [4:0]  db_m [0:15];
    logic [4:0]  db_p [0:15];
    logic [24:0] db_v [0:15];
    int          db_pop;

    assign db_mask  = db_m[db_index[3:0]];
    assign db_pole  = db_p[db_index[3:0]];
    assign db_var   = db_v[db_index[3:0]];
    assign db_error = (int'(db_index) >= db_pop);

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_tests = 0;
    int n_fail  = 0;

    // Scan observation results
    int s_done, s_done_idx, s_units, s_useen, s_uvar, s_uval;
    int s_rd_cnt, s_rd_max, s_conf, s_cidx, s_err;

    typedef struct packed {
        logic [4:0]  mask;
        logic [4:0]  pole;
        logic [24:0] vars;
        logic [31:0] av;
        logic [31:0] vv;
        logic        exp_unit;
        logic [4:0]  exp_var;
        logic        exp_val;
        logic        exp_conf;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [24:0] pv(input int a, input int b, input int c,
                                       input int d, input int e);
        pv = {e[4:0], d[4:0], c[4:0], b[4:0], a[4:0]};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Observe the running scan at each negedge until done or budget expiry.
    task automatic wait_done(input int budget);
        s_done = 0; s_done_idx = -1; s_units = 0; s_useen = 0; s_uvar = 0; s_uval = 0;
        s_rd_cnt = 0; s_rd_max = -1; s_conf = 0; s_cidx = 0; s_err = 0;
        for (int c = 0; c < budget; c++) begin
            if (db_read) begin
                s_rd_cnt++;
                if (int'(db_index) > s_rd_max) s_rd_max = int'(db_index);
            end
            if (unit_valid) begin
                if (s_useen == 0) begin
                    s_useen = 1;
                    s_uvar  = int'(unit_var);
                    s_uval  = int'(unit_val);
                end
                if (unit_ready) s_units++;
            end
            if (done) begin
                s_done     = 1;
                s_done_idx = c;
                s_conf     = int'(conflict);
                s_cidx     = int'(conflict_idx);
                s_err      = int'(error);
                break;
            end
            @(negedge clock);
        end
        chk("done_seen", s_done, 1);
        if (s_done == 1) begin
            @(negedge clock);
            chk("done_one_cycle", int'(done), 0);
            chk("idle_after_done", int'(busy), 0);
        end
    endtask

    task automatic run_scan(input logic [8:0] n, input int budget);
        num_clauses = n;
        start       = 1'b1;
        @(negedge clock);
        start       = 1'b0;
        wait_done(budget);
    endtask

    task automatic wait_unit(input int budget);
        for (int c = 0; c < budget; c++) begin
            if (unit_valid) break;
            @(negedge clock);
        end
        chk("unit_valid_seen", int'(unit_valid), 1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; unit_ready = 1'b1; num_clauses = '0;
        assign_valid = '0; assign_val = '0; db_pop = 16;
        for (int k = 0; k < 16; k++) begin
            db_m[k] = '0; db_p[k] = '0; db_v[k] = '0;
        end

        //          mask      pole      vars               av          vv          unit  var    val   conf
        vecs[0]  = '{5'b00011, 5'b00011, pv(1,2,0,0,0),     32'h2,      32'h2,      1'b0, 5'd0,  1'b0, 1'b0};
        vecs[1]  = '{5'b00001, 5'b00000, pv(3,0,0,0,0),     32'h8,      32'h0,      1'b0, 5'd0,  1'b0, 1'b0};
        vecs[2]  = '{5'b00111, 5'b00101, pv(1,2,4,0,0),     32'h6,      32'h4,      1'b1, 5'd4,  1'b1, 1'b0};
        vecs[3]  = '{5'b00011, 5'b00011, pv(1,2,0,0,0),     32'h6,      32'h0,      1'b0, 5'd0,  1'b0, 1'b1};
        vecs[4]  = '{5'b00000, 5'b11111, pv(1,2,3,4,5),     32'h0,      32'h0,      1'b0, 5'd0,  1'b0, 1'b1};
        vecs[5]  = '{5'b00011, 5'b00011, pv(5,6,0,0,0),     32'h0,      32'h0,      1'b0, 5'd0,  1'b0, 1'b0};
        vecs[6]  = '{5'b00001, 5'b00000, pv(7,0,0,0,0),     32'h0,      32'h0,      1'b1, 5'd7,  1'b0, 1'b0};
        vecs[7]  = '{5'b00011, 5'b00011, pv(9,9,0,0,0),     32'h0,      32'h0,      1'b0, 5'd0,  1'b0, 1'b0};
        vecs[8]  = '{5'b11111, 5'b10000, pv(10,11,12,13,31), 32'h3C00,  32'h3C00,   1'b1, 5'd31, 1'b1, 1'b0};
        vecs[9]  = '{5'b00001, 5'b00011, pv(2,3,0,0,0),     32'h4,      32'h0,      1'b0, 5'd0,  1'b0, 1'b1};
        vecs[10] = '{5'b00010, 5'b00001, pv(1,0,0,0,0),     32'h2,      32'h2,      1'b1, 5'd0,  1'b0, 1'b0};
        vecs[11] = '{5'b00011, 5'b00001, pv(9,9,0,0,0),     32'h200,    32'h200,    1'b0, 5'd0,  1'b0, 1'b0};

        repeat (3) @(negedge clock);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_conflict", int'(conflict), 0);
        chk("rst_conflict_idx", int'(conflict_idx), 0);
        chk("rst_error", int'(error), 0);
        chk("rst_unit", int'({unit_valid, unit_var, unit_val}), 0);
        chk("rst_db", int'({db_read, db_index}), 0);
        reset = 1'b0;
        @(negedge clock);

        // Single-clause classification table
        for (int i = 0; i < 12; i++) begin
            db_m[0] = vecs[i].mask;
            db_p[0] = vecs[i].pole;
            db_v[0] = vecs[i].vars;
            assign_valid = vecs[i].av;
            assign_val   = vecs[i].vv;
            run_scan(9'd1, 50);
            chk($sformatf("v%0d_unit", i), s_useen, int'(vecs[i].exp_unit));
            if (vecs[i].exp_unit) begin
                chk($sformatf("v%0d_unit_var", i), s_uvar, int'(vecs[i].exp_var));
                chk($sformatf("v%0d_unit_val", i), s_uval, int'(vecs[i].exp_val));
            end
            chk($sformatf("v%0d_conflict", i), s_conf, int'(vecs[i].exp_conf));
            chk($sformatf("v%0d_error", i), s_err, 0);
            chk($sformatf("v%0d_latency", i), s_done_idx,
                vecs[i].exp_conf ? 2 : (vecs[i].exp_unit ? 4 : 3));
        end

        // Two clauses, both satisfied: no unit, 3 cycles each
        db_m[0] = 5'b00011; db_p[0] = 5'b00011; db_v[0] = pv(1,2,0,0,0);
        db_m[1] = 5'b00001; db_p[1] = 5'b00000; db_v[1] = pv(3,0,0,0,0);
        assign_valid = 32'hA; assign_val = 32'h2;
        run_scan(9'd2, 50);
        chk("two_sat_unit", s_useen, 0);
        chk("two_sat_conflict", s_conf, 0);
        chk("two_sat_latency", s_done_idx, 6);
        chk("two_sat_reads", s_rd_cnt, 2);

        // Unit with consumer stall
        db_m[0] = 5'b00111; db_p[0] = 5'b00101; db_v[0] = pv(1,2,4,0,0);
        assign_valid = 32'h6; assign_val = 32'h4;
        unit_ready = 1'b0;
        num_clauses = 9'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_unit(20);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d_valid", k), int'(unit_valid), 1);
            chk($sformatf("stall%0d_var", k), int'(unit_var), 4);
            chk($sformatf("stall%0d_val", k), int'(unit_val), 1);
            @(negedge clock);
        end
        unit_ready = 1'b1;
        wait_done(20);
        chk("stall_handshakes", s_units, 1);
        chk("stall_resume_latency", s_done_idx, 2);

        // Conflict on clause 2 of 4 stops the scan
        db_m[0] = 5'b00001; db_p[0] = 5'b00001; db_v[0] = pv(1,0,0,0,0);
        db_m[1] = 5'b00011; db_p[1] = 5'b00011; db_v[1] = pv(5,6,0,0,0);
        db_m[2] = 5'b00011; db_p[2] = 5'b00010; db_v[2] = pv(1,3,0,0,0);
        db_m[3] = 5'b00001; db_p[3] = 5'b00001; db_v[3] = pv(1,0,0,0,0);
        assign_valid = 32'hA; assign_val = 32'h2;
        run_scan(9'd4, 60);
        chk("cfl_conflict", s_conf, 1);
        chk("cfl_idx", s_cidx, 2);
        chk("cfl_max_index", s_rd_max, 2);
        chk("cfl_error", s_err, 0);
        chk("cfl_latency", s_done_idx, 8);
        repeat (3) @(negedge clock);
        chk("cfl_held", int'(conflict), 1);
        chk("cfl_idx_held", int'(conflict_idx), 2);

        // Empty scan: immediate done, clears held conflict
        run_scan(9'd0, 10);
        chk("empty_latency", s_done_idx, 0);
        chk("empty_reads", s_rd_cnt, 0);
        chk("empty_conflict", s_conf, 0);
        chk("empty_error", s_err, 0);

        // Database error at index 5 of 6
        for (int k = 0; k < 5; k++) begin
            db_m[k] = 5'b00001; db_p[k] = 5'b00001; db_v[k] = pv(1,0,0,0,0);
        end
        assign_valid = 32'h2; assign_val = 32'h2;
        db_pop = 5;
        run_scan(9'd6, 100);
        chk("dberr_error", s_err, 1);
        chk("dberr_conflict", s_conf, 0);
        chk("dberr_max_index", s_rd_max, 5);
        chk("dberr_latency", s_done_idx, 17);
        db_pop = 16;

        // Reset while presenting a unit, then a clean scan
        db_m[0] = 5'b00111; db_p[0] = 5'b00101; db_v[0] = pv(1,2,4,0,0);
        assign_valid = 32'h6; assign_val = 32'h4;
        unit_ready = 1'b0;
        num_clauses = 9'd1;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        wait_unit(20);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_busy", int'(busy), 0);
        chk("rstmid_unit_valid", int'(unit_valid), 0);
        chk("rstmid_done", int'(done), 0);
        chk("rstmid_error", int'(error), 0);
        reset = 1'b0;
        unit_ready = 1'b1;
        @(negedge clock);
        run_scan(9'd1, 50);
        chk("rstmid_rerun_unit", s_useen, 1);
        chk("rstmid_rerun_var", s_uvar, 4);
        chk("rstmid_rerun_latency", s_done_idx, 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
